// File: rtl/esi_loopback_buffer.sv
// esi_loopback_buffer: small FIFO that loops ESI endpoint output messages back
// into the endpoint input. One-cycle latency, full-throughput valid/ready on both
// sides, InReady driven purely from registered state.
// Optional statistics counters are enabled by defining ESI_LOOPBACK_STATS_EN.
module esi_loopback_buffer #(
    parameter int TYPE_SIZE_BITS = 192,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [TYPE_SIZE_BITS-1:0] InData,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [TYPE_SIZE_BITS-1:0] OutData,
    output logic [$clog2(DEPTH):0]    Occupancy,
    output logic [31:0]               MsgsIn,
    output logic [31:0]               MsgsOut
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    // Message storage; no reset needed, contents only read while occupied.
    logic [TYPE_SIZE_BITS-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   occ_reg;
    // Held low through reset so InReady reads 0 in the reset cycle.
    logic          active_reg;

    logic push;
    logic pop;

    assign InReady   = active_reg && (occ_reg < FULL_COUNT);
    assign OutValid  = (occ_reg != '0);
    assign push      = InValid && InReady;
    assign pop       = OutValid && OutReady;
    assign Occupancy = occ_reg;

    // Head is read straight from storage at the read pointer (distributed RAM),
    // which gives the one-cycle push-to-present latency. It only changes on a pop
    // or on the first push into an empty buffer, so it is stable while stalled.
    assign OutData = mem[rd_ptr_reg];

    // Store accepted messages at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= InData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            active_reg <= 1'b1;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

`ifdef ESI_LOOPBACK_STATS_EN
    logic [31:0] msgs_in_reg;
    logic [31:0] msgs_out_reg;

    // Free-running message counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            msgs_in_reg  <= '0;
            msgs_out_reg <= '0;
        end else begin
            if (push) begin
                msgs_in_reg <= msgs_in_reg + 32'd1;
            end
            if (pop) begin
                msgs_out_reg <= msgs_out_reg + 32'd1;
            end
        end
    end

    assign MsgsIn  = msgs_in_reg;
    assign MsgsOut = msgs_out_reg;
`else
    assign MsgsIn  = '0;
    assign MsgsOut = '0;
`endif

endmodule

// File: tb/tb_esi_loopback_buffer.sv
// Directed self-checking bench for esi_loopback_buffer (DEPTH=4, 192-bit messages).
// Expected counter values follow ESI_LOOPBACK_STATS_EN when it is defined.
module tb_esi_loopback_buffer;

    localparam int W = 192;
    localparam int D = 4;
`ifdef ESI_LOOPBACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk;
    logic         rstn;
    logic         InValid;
    logic         InReady;
    logic [W-1:0] InData;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] OutData;
    logic [2:0]   Occupancy;
    logic [31:0]  MsgsIn;
    logic [31:0]  MsgsOut;

    int checks;
    int failures;

    esi_loopback_buffer #(.TYPE_SIZE_BITS(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .Occupancy(Occupancy),
        .MsgsIn   (MsgsIn),
        .MsgsOut  (MsgsOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinctive message pattern so every 64-bit word is checked.
    function automatic logic [W-1:0] mk(input int k);
        return {32'hC0DE_0000 | 32'(k), 32'(k * 3), 64'hFEDC_BA98_7654_3210, 64'(k)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input int cycles);
        rstn = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b0;
        repeat (cycles) step();
    endtask

    logic [W-1:0] exp_q[$];
    int pushed;
    int popped;
    int occ_m;
    bit pa;
    bit pp;

    initial begin
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b0;
        InData = '0;

        // Reset state
        apply_reset(2);
        chk_n("rst_occ", int'(Occupancy), 0);
        chk_n("rst_outvalid", int'(OutValid), 0);
        chk_n("rst_inready", int'(InReady), 0);
        chk_n("rst_msgsin", int'(MsgsIn), 0);
        chk_n("rst_msgsout", int'(MsgsOut), 0);
        rstn = 1'b1;
        step();
        chk_n("post_rst_inready", int'(InReady), 1);
        chk_n("post_rst_occ", int'(Occupancy), 0);

        // Three back-to-back pushes with the output stalled; head must stay on message 1
        for (int k = 1; k <= 3; k++) begin
            InValid = 1'b1;
            InData = mk(k);
            step();
            $display("push data=%0h occ=%0d", mk(k), Occupancy);
            chk_n("b2b_occ", int'(Occupancy), k);
            chk_d("b2b_head", OutData, mk(1));
            chk_n("b2b_outvalid", int'(OutValid), 1);
        end
        InValid = 1'b0;
        chk_n("b2b_inready", int'(InReady), 1);
        chk_n("b2b_msgsin", int'(MsgsIn), STATS ? 3 : 0);

        // Mid-operation reset discards the three stored messages
        apply_reset(1);
        chk_n("midrst_occ", int'(Occupancy), 0);
        chk_n("midrst_outvalid", int'(OutValid), 0);
        chk_n("midrst_msgsin", int'(MsgsIn), 0);
        chk_n("midrst_msgsout", int'(MsgsOut), 0);
        rstn = 1'b1;
        step();
        InValid = 1'b1;
        InData = mk(50);
        step();
        InValid = 1'b0;
        chk_n("midrst_new_occ", int'(Occupancy), 1);
        chk_d("midrst_new_data", OutData, mk(50));
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk_n("midrst_drain_occ", int'(Occupancy), 0);
        chk_n("midrst_drain_outvalid", int'(OutValid), 0);

        // Popping an empty buffer must not underflow
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk_n("empty_pop_occ", int'(Occupancy), 0);
        chk_n("empty_pop_msgsout", int'(MsgsOut), STATS ? 1 : 0);

        // InValid held for 6 cycles with stalled output: exactly 4 accepted
        for (int i = 0; i < 6; i++) begin
            InValid = 1'b1;
            InData = mk(10 + i);
            step();
            chk_n("fill_inready", int'(InReady), (i < 3) ? 1 : 0);
        end
        InValid = 1'b0;
        chk_n("fill_occ", int'(Occupancy), 4);
        OutReady = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk_n("fill_drain_outvalid", int'(OutValid), 1);
            chk_d("fill_drain_data", OutData, mk(10 + j));
            $display("pop data=%0h", OutData);
            step();
        end
        OutReady = 1'b0;
        chk_n("fill_drain_occ", int'(Occupancy), 0);
        chk_n("fill_msgsin", int'(MsgsIn), STATS ? 5 : 0);
        chk_n("fill_msgsout", int'(MsgsOut), STATS ? 5 : 0);

        // Full buffer: pop with InValid high must not push in the same cycle
        for (int i = 0; i < 4; i++) begin
            InValid = 1'b1;
            InData = mk(20 + i);
            step();
        end
        chk_n("full_occ", int'(Occupancy), 4);
        InData = mk(24);
        OutReady = 1'b1;
        step();
        chk_n("full_popnopush_occ", int'(Occupancy), 3);
        chk_d("full_popnopush_head", OutData, mk(21));
        chk_n("full_popnopush_inready", int'(InReady), 1);
        OutReady = 1'b0;
        step();
        InValid = 1'b0;
        chk_n("full_repush_occ", int'(Occupancy), 4);

        // Drop to occupancy 2, then 10 simultaneous push/pop cycles across pointer wraps
        OutReady = 1'b1;
        step();
        step();
        OutReady = 1'b0;
        chk_n("sim_pre_occ", int'(Occupancy), 2);
        for (int i = 0; i < 10; i++) begin
            InValid = 1'b1;
            OutReady = 1'b1;
            InData = mk(30 + i);
            chk_d("sim_head", OutData, (i == 0) ? mk(23) : (i == 1) ? mk(24) : mk(28 + i));
            step();
            chk_n("sim_occ", int'(Occupancy), 2);
        end
        InValid = 1'b0;
        OutReady = 1'b0;
        chk_d("sim_final_head", OutData, mk(38));
        chk_n("sim_msgsin", int'(MsgsIn), STATS ? 20 : 0);
        chk_n("sim_msgsout", int'(MsgsOut), STATS ? 18 : 0);

        // Fresh reset, then 20 pushes / 20 pops with random OutReady
        apply_reset(1);
        rstn = 1'b1;
        step();
        pushed = 0;
        popped = 0;
        occ_m = 0;
        for (int cyc = 0; cyc < 400 && (pushed < 20 || popped < 20); cyc++) begin
            InValid = (pushed < 20);
            InData = mk(100 + pushed);
            OutReady = 1'($urandom_range(0, 1));
            chk_n("rnd_inready", int'(InReady), (occ_m < D) ? 1 : 0);
            chk_n("rnd_outvalid", int'(OutValid), (occ_m > 0) ? 1 : 0);
            chk_n("rnd_occ", int'(Occupancy), occ_m);
            chk_n("rnd_msgsin", int'(MsgsIn), STATS ? pushed : 0);
            chk_n("rnd_msgsout", int'(MsgsOut), STATS ? popped : 0);
            pa = InValid && (occ_m < D);
            pp = OutReady && (occ_m > 0);
            if (pp) begin
                chk_d("rnd_data", OutData, exp_q[0]);
                $display("pop data=%0h", OutData);
                void'(exp_q.pop_front());
                popped++;
            end
            if (pa) begin
                exp_q.push_back(mk(100 + pushed));
                pushed++;
            end
            occ_m = occ_m + int'(pa) - int'(pp);
            step();
        end
        InValid = 1'b0;
        OutReady = 1'b0;
        chk_n("rnd_completed", ((pushed == 20) && (popped == 20)) ? 1 : 0, 1);
        chk_n("rnd_final_msgsin", int'(MsgsIn), STATS ? 20 : 0);
        chk_n("rnd_final_msgsout", int'(MsgsOut), STATS ? 20 : 0);
        chk_n("rnd_final_occ", int'(Occupancy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
